// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Brief    : E-stage multiply/divide unit with HI/LO and fixed-latency busy
//            countdown; optional madd/maddu/msub/msubu under MDU_MADD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rdata
);

    localparam logic [3:0] c_OP_MULT  = 4'd1;
    localparam logic [3:0] c_OP_MULTU = 4'd2;
    localparam logic [3:0] c_OP_DIV   = 4'd3;
    localparam logic [3:0] c_OP_DIVU  = 4'd4;
    localparam logic [3:0] c_OP_MFHI  = 4'd5;
    localparam logic [3:0] c_OP_MFLO  = 4'd6;
    localparam logic [3:0] c_OP_MTHI  = 4'd7;
    localparam logic [3:0] c_OP_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd9;
    localparam logic [3:0] c_OP_MADDU = 4'd10;
    localparam logic [3:0] c_OP_MSUB  = 4'd11;
    localparam logic [3:0] c_OP_MSUBU = 4'd12;
`endif
    localparam logic [3:0] c_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] c_DIV_CNT  = 4'(DIV_CYCLES);

    logic [3:0]  r_count;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_is_mac;
    logic        w_is_sub;
    logic        w_signed;
    logic [63:0] w_ext_a;
    logic [63:0] w_ext_b;
    logic [63:0] w_prod;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_qmag;
    logic [31:0] w_rmag;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    always_comb begin
        w_is_mul = (mdu_op == c_OP_MULT) || (mdu_op == c_OP_MULTU);
        w_is_div = (mdu_op == c_OP_DIV)  || (mdu_op == c_OP_DIVU);
        w_signed = (mdu_op == c_OP_MULT) || (mdu_op == c_OP_DIV);
        w_is_mac = 1'b0;
        w_is_sub = 1'b0;
`ifdef MDU_MADD_EN
        w_is_mac = (mdu_op == c_OP_MADD) || (mdu_op == c_OP_MADDU) ||
                   (mdu_op == c_OP_MSUB) || (mdu_op == c_OP_MSUBU);
        w_is_sub = (mdu_op == c_OP_MSUB) || (mdu_op == c_OP_MSUBU);
        if ((mdu_op == c_OP_MADD) || (mdu_op == c_OP_MSUB))
            w_signed = 1'b1;
`endif
    end

    assign start = (w_is_mul || w_is_div || w_is_mac) && !req;
    assign busy  = (r_count != 4'd0);
    assign hi    = r_hi;
    assign lo    = r_lo;
    assign rdata = (mdu_op == c_OP_MFHI) ? r_hi :
                   (mdu_op == c_OP_MFLO) ? r_lo : 32'd0;

    // Sign-extending both operands to 64 bits lets one unsigned multiplier
    // produce the correct low 64 bits for signed and unsigned products.
    assign w_ext_a = w_signed ? {{32{a[31]}}, a} : {32'd0, a};
    assign w_ext_b = w_signed ? {{32{b[31]}}, b} : {32'd0, b};
    assign w_prod  = w_ext_a * w_ext_b;

    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_abs_a = (w_signed && a[31]) ? (~a + 32'd1) : a;
    assign w_abs_b = (w_signed && b[31]) ? (~b + 32'd1) : b;
    assign w_qmag  = (b == 32'd0) ? 32'd0 : (w_abs_a / w_abs_b);
    assign w_rmag  = (b == 32'd0) ? 32'd0 : (w_abs_a % w_abs_b);

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        if (w_is_mul) begin
            {w_res_hi, w_res_lo} = w_prod;
        end else if (w_is_div) begin
            if (b != 32'd0) begin
                w_res_lo = (w_signed && (a[31] ^ b[31])) ? (~w_qmag + 32'd1) : w_qmag;
                w_res_hi = (w_signed && a[31]) ? (~w_rmag + 32'd1) : w_rmag;
            end
        end else if (w_is_mac) begin
            if (w_is_sub)
                {w_res_hi, w_res_lo} = {r_hi, r_lo} - w_prod;
            else
                {w_res_hi, w_res_lo} = {r_hi, r_lo} + w_prod;
        end
    end

    // A start while busy falls into the countdown branch and is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count   <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
        end else if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
            if (r_count == 4'd1) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (start) begin
            r_count   <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
            r_pend_hi <= w_res_hi;
            r_pend_lo <= w_res_lo;
        end else if (!req && (mdu_op == c_OP_MTHI)) begin
            r_hi <= a;
        end else if (!req && (mdu_op == c_OP_MTLO)) begin
            r_lo <= a;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Brief    : Directed self-checking bench for mdu_unit (MDU_MADD_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rdata;

    int n_tests;
    int n_fail;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mdu_op  (mdu_op),
        .a       (a),
        .b       (b),
        .req     (req),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rdata   (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic r);
        @(negedge clk);
        mdu_op = op;
        a      = x;
        b      = y;
        req    = r;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mdu_op = 4'd0;
        req    = 1'b0;
    endtask

    // Counts remaining busy cycles; the bound keeps a stuck busy from hanging.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mdu_op  = 4'd0;
        a       = 32'd0;
        b       = 32'd0;
        req     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: hi=%h lo=%h busy=%b expected 0/0/0", hi, lo, busy);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_mult();
        int n;
        drive(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL mult_start: start=%b expected 1", start);
        end
        step();
        count_busy(n);
        n_tests++;
        if (n != 5) begin
            n_fail++;
            $display("FAIL mult_busy: cycles=%0d expected 5", n);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL mult_result: hi=%h lo=%h expected ffffffff/fffffffe", hi, lo);
        end
        drive(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (n != 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL multu: cycles=%0d hi=%h lo=%h expected 5 00000001/fffffffe", n, hi, lo);
        end
    endtask

    task automatic test_div();
        int n;
        drive(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (n != 10) begin
            n_fail++;
            $display("FAIL div_busy: cycles=%0d expected 10", n);
        end
        n_tests++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL div_result: hi=%h lo=%h expected ffffffff/fffffffd", hi, lo);
        end
        drive(4'd4, 32'd7, 32'd0, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (n != 10 || hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
            n_fail++;
            $display("FAIL divu_by_zero: cycles=%0d hi=%h lo=%h expected 10 ffffffff/fffffffd",
                     n, hi, lo);
        end
        drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL div_overflow: hi=%h lo=%h expected 00000000/80000000", hi, lo);
        end
        drive(4'd4, 32'd100, 32'd7, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            n_fail++;
            $display("FAIL divu: hi=%h lo=%h expected 00000002/0000000e", hi, lo);
        end
    endtask

    task automatic test_move();
        drive(4'd7, 32'h0000_1234, 32'd0, 1'b0);
        step();
        n_tests++;
        if (hi !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mthi: hi=%h expected 00001234", hi);
        end
        drive(4'd8, 32'h0000_5678, 32'd0, 1'b1);
        step();
        n_tests++;
        if (lo !== 32'd14) begin
            n_fail++;
            $display("FAIL mtlo_req: lo=%h expected 0000000e", lo);
        end
        drive(4'd6, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (rdata !== 32'd14) begin
            n_fail++;
            $display("FAIL mflo: rdata=%h expected 0000000e", rdata);
        end
        drive(4'd5, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (rdata !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL mfhi: rdata=%h expected 00001234", rdata);
        end
        drive(4'd0, 32'd0, 32'd0, 1'b0);
        n_tests++;
        if (rdata !== 32'd0) begin
            n_fail++;
            $display("FAIL rdata_none: rdata=%h expected 00000000", rdata);
        end
    endtask

    task automatic test_req();
        int n;
        drive(4'd1, 32'd9, 32'd9, 1'b1);
        n_tests++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL req_start: start=%b expected 0", start);
        end
        step();
        n_tests++;
        if (busy !== 1'b0 || lo !== 32'd14) begin
            n_fail++;
            $display("FAIL req_nostart: busy=%b lo=%h expected 0 0000000e", busy, lo);
        end
        drive(4'd1, 32'd6, 32'd7, 1'b0);
        step();
        @(posedge clk);
        #1;
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        count_busy(n);
        n_tests++;
        if (n != 3 || hi !== 32'd0 || lo !== 32'd42) begin
            n_fail++;
            $display("FAIL req_midbusy: remaining=%0d hi=%h lo=%h expected 3 00000000/0000002a",
                     n, hi, lo);
        end
        drive(4'd13, 32'd1, 32'd1, 1'b0);
        n_tests++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL op13_start: start=%b expected 0", start);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        drive(4'd1, 32'd3, 32'd4, 1'b0);
        step();
        drive(4'd2, 32'd5, 32'd5, 1'b0);
        step();
        drive(4'd7, 32'hDEAD_BEEF, 32'd0, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (n != 3 || hi !== 32'd0 || lo !== 32'd12) begin
            n_fail++;
            $display("FAIL back_to_back: remaining=%0d hi=%h lo=%h expected 3 00000000/0000000c",
                     n, hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        drive(4'd7, 32'h0000_00AA, 32'd0, 1'b0);
        step();
        drive(4'd3, 32'd100, 32'd3, 1'b0);
        step();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b hi=%h lo=%h expected 0 0/0", busy, hi, lo);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_nocommit: busy=%b hi=%h lo=%h expected 0 0/0", busy, hi, lo);
        end
        n = 0;
    endtask

    task automatic test_madd();
        int n;
        drive(4'd7, 32'd0, 32'd0, 1'b0);
        step();
        drive(4'd8, 32'hFFFF_FFFF, 32'd0, 1'b0);
        step();
        drive(4'd10, 32'd1, 32'd1, 1'b0);
`ifdef MDU_MADD_EN
        n_tests++;
        if (start !== 1'b1) begin
            n_fail++;
            $display("FAIL maddu_start: start=%b expected 1", start);
        end
        step();
        count_busy(n);
        n_tests++;
        if (n != 5 || hi !== 32'd1 || lo !== 32'd0) begin
            n_fail++;
            $display("FAIL maddu: cycles=%0d hi=%h lo=%h expected 5 00000001/00000000", n, hi, lo);
        end
        drive(4'd11, 32'd2, 32'd1, 1'b0);
        step();
        count_busy(n);
        n_tests++;
        if (hi !== 32'd0 || lo !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL msub: hi=%h lo=%h expected 00000000/fffffffe", hi, lo);
        end
`else
        n_tests++;
        if (start !== 1'b0) begin
            n_fail++;
            $display("FAIL maddu_off_start: start=%b expected 0", start);
        end
        step();
        count_busy(n);
        n_tests++;
        if (n != 0 || hi !== 32'd0 || lo !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL maddu_off: busy_cycles=%0d hi=%h lo=%h expected 0 00000000/ffffffff",
                     n, hi, lo);
        end
`endif
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_req();
        test_back_to_back();
        test_reset_mid();
        test_madd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
